// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - FSM states, requester IDs, size code and grant helper for mem_port_arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_ACCESS = 2'd1,
        MA_RESP   = 2'd2
    } ma_state_e;

    typedef enum logic {
        MA_FETCH = 1'b0,
        MA_DATA  = 1'b1
    } ma_req_e;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // tie_winner only matters when both requesters are asking at once
    function automatic ma_req_e ma_pick(input logic i_req, input logic d_req, input ma_req_e tie_winner);
        if (i_req && d_req) begin
            return tie_winner;
        end else if (d_req) begin
            return MA_DATA;
        end
        return MA_FETCH;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the load_store port between fetch and data requesters
// Optional round-robin tie-break: define MEM_ARB_ROUND_ROBIN_EN (default is fixed data priority).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    input  logic        d_wr,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_wr,
    output logic        mem_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exception
);

    localparam logic [3:0] ACCESS_CNT = 4'(LATENCY);

    ma_state_e   state_q, state_d;
    ma_req_e     owner_q, owner_d;
    ma_req_e     grant, tie_winner;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  mem_size_q, mem_size_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    ma_req_e last_grant_q, last_grant_d;

    assign tie_winner = (last_grant_q == MA_FETCH) ? MA_DATA : MA_FETCH;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last_grant_q <= MA_FETCH;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign tie_winner = MA_DATA;
`endif

    assign grant = ma_pick(i_req, d_req, tie_winner);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        mem_wr_d    = mem_wr_q;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            MA_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant;
                    cnt_d   = ACCESS_CNT;
                    state_d = MA_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant;
`endif
                    if (grant == MA_DATA) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_size_d  = d_size;
                        mem_wr_d    = d_wr;
                    end else begin
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        mem_size_d  = SIZE_WORD;
                        mem_wr_d    = 1'b0;
                    end
                end
            end
            MA_ACCESS: begin
                // counter runs LATENCY..0, giving LATENCY+1 enabled cycles
                if (cnt_q == 4'd0) begin
                    state_d = MA_RESP;
                    if (owner_q == MA_DATA) begin
                        d_rdata_d = mem_rdata;
                        d_err_d   = mem_exception;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_err_d   = mem_exception;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MA_RESP: begin
                state_d = MA_IDLE;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= MA_IDLE;
            owner_q     <= MA_FETCH;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            mem_wr_q    <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            mem_wr_q    <= mem_wr_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    // enable and acks decode from state so an asynchronous reset clears them at once
    assign mem_en    = (state_q == MA_ACCESS);
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign i_ack     = (state_q == MA_RESP) && (owner_q == MA_FETCH);
    assign d_ack     = (state_q == MA_RESP) && (owner_q == MA_DATA);
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule
